// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states, mode word helper.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  // Widest address bus the mode word helper can describe.
  localparam int unsigned MODE_WORD_W = 32;

  typedef enum logic [2:0] {
    INIT_WAIT_PWR,
    INIT_PRECHARGE,
    INIT_WAIT_TRP,
    INIT_AUTO_REF,
    INIT_WAIT_TRFC,
    INIT_LOAD_MODE,
    INIT_WAIT_TMRD,
    INIT_DONE
  } init_state_t;

  // Mode register word: {zeros, WB, 2'b00, CL, BT, BL}; bits at or above addr_w are cleared.
  function automatic logic [MODE_WORD_W-1:0] sdram_mode_word(
    input int unsigned addr_w,
    input logic        wb,
    input logic [2:0]  cl,
    input logic        bt,
    input logic [2:0]  bl
  );
    logic [MODE_WORD_W-1:0] w;
    w      = '0;
    w[9]   = wb;
    w[6:4] = cl;
    w[3]   = bt;
    w[2:0] = bl;
    for (int unsigned i = 0; i < MODE_WORD_W; i++) begin
      if (i >= addr_w) w[i] = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable down-counter that holds at zero; used for all init wait intervals.
module sdram_init_timer #(
  parameter int unsigned W = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer with re-initialisation support.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned BA_W          = 2,
  parameter int unsigned T_POWERUP_CYC = 20000,
  parameter int unsigned T_RP_CYC      = 2,
  parameter int unsigned T_RFC_CYC     = 7,
  parameter int unsigned T_MRD_CYC     = 3,
  parameter int unsigned REFRESH_CNT   = 2,
  parameter int unsigned CAS_LAT       = 3,
  parameter int unsigned BURST_TYPE    = 0,
  parameter logic [2:0]  BURST_LEN     = 3'b111,
  parameter int unsigned WB_MODE       = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              reinit_req,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done
);

  if (ADDR_W < 11 || ADDR_W > MODE_WORD_W) begin : g_bad_addr_w
    $error("sdram_init_ctrl: ADDR_W must be in 11..32");
  end
  if (BA_W < 1) begin : g_bad_ba_w
    $error("sdram_init_ctrl: BA_W must be >= 1");
  end
  if (T_POWERUP_CYC < 1 || T_RP_CYC < 1 || T_RFC_CYC < 1 || T_MRD_CYC < 1) begin : g_bad_timing
    $error("sdram_init_ctrl: all timing parameters must be >= 1");
  end
  if (REFRESH_CNT < 1 || REFRESH_CNT > 15) begin : g_bad_refresh
    $error("sdram_init_ctrl: REFRESH_CNT must be in 1..15");
  end
  if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cas
    $error("sdram_init_ctrl: CAS_LAT must be 2 or 3");
  end
  if (BURST_TYPE > 1 || WB_MODE > 1) begin : g_bad_mode_bits
    $error("sdram_init_ctrl: BURST_TYPE and WB_MODE must be 0 or 1");
  end

  localparam int unsigned T_MAX_A = (T_POWERUP_CYC > T_RP_CYC)  ? T_POWERUP_CYC : T_RP_CYC;
  localparam int unsigned T_MAX_B = (T_RFC_CYC > T_MRD_CYC)     ? T_RFC_CYC     : T_MRD_CYC;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B)         ? T_MAX_A       : T_MAX_B;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);
  localparam int unsigned RC_W    = $clog2(REFRESH_CNT + 1);

  // Command state lasts one cycle and the wait state T-1 cycles; the wait is
  // entered one cycle after the command, hence T-2. T=1 skips the wait state.
  localparam logic [TMR_W-1:0] LD_PWR = TMR_W'(T_POWERUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_RP  = TMR_W'((T_RP_CYC  > 1) ? T_RP_CYC  - 2 : 0);
  localparam logic [TMR_W-1:0] LD_RFC = TMR_W'((T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0);
  localparam logic [TMR_W-1:0] LD_MRD = TMR_W'((T_MRD_CYC > 1) ? T_MRD_CYC - 2 : 0);

  localparam logic [MODE_WORD_W-1:0] MODE_WORD =
    sdram_mode_word(ADDR_W, 1'(WB_MODE), 3'(CAS_LAT), 1'(BURST_TYPE), BURST_LEN);

  init_state_t       state_q, state_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [RC_W-1:0]   ref_cnt_inc;
  logic              pwr_arm_q, pwr_arm_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic [3:0]        cmd_d;
  logic [BA_W-1:0]   ba_d;
  logic [ADDR_W-1:0] addr_d;
  logic              done_d;

  sdram_init_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign ref_cnt_inc = ref_cnt_q + RC_W'(1);

  // State, refresh counter and power-up arm flag registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= INIT_WAIT_PWR;
      ref_cnt_q <= '0;
      pwr_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      pwr_arm_q <= pwr_arm_d;
    end
  end

  // Next-state, timer load and refresh count logic.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    pwr_arm_d = pwr_arm_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      // Reset leaves the timer at zero, so the first cycle out of reset
      // arms it with the full power-up count.
      INIT_WAIT_PWR: begin
        if (!pwr_arm_q) begin
          tmr_load  = 1'b1;
          tmr_val   = LD_PWR;
          pwr_arm_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = INIT_PRECHARGE;
        end
      end
      INIT_PRECHARGE: begin
        if (T_RP_CYC > 1) begin
          state_d  = INIT_WAIT_TRP;
          tmr_load = 1'b1;
          tmr_val  = LD_RP;
        end else begin
          state_d = INIT_AUTO_REF;
        end
      end
      INIT_WAIT_TRP: begin
        if (tmr_zero) state_d = INIT_AUTO_REF;
      end
      INIT_AUTO_REF: begin
        ref_cnt_d = ref_cnt_inc;
        if (T_RFC_CYC > 1) begin
          state_d  = INIT_WAIT_TRFC;
          tmr_load = 1'b1;
          tmr_val  = LD_RFC;
        end else if (ref_cnt_inc < RC_W'(REFRESH_CNT)) begin
          state_d = INIT_AUTO_REF;
        end else begin
          state_d = INIT_LOAD_MODE;
        end
      end
      INIT_WAIT_TRFC: begin
        if (tmr_zero) begin
          state_d = (ref_cnt_q < RC_W'(REFRESH_CNT)) ? INIT_AUTO_REF : INIT_LOAD_MODE;
        end
      end
      INIT_LOAD_MODE: begin
        if (T_MRD_CYC > 1) begin
          state_d  = INIT_WAIT_TMRD;
          tmr_load = 1'b1;
          tmr_val  = LD_MRD;
        end else begin
          state_d = INIT_DONE;
        end
      end
      INIT_WAIT_TMRD: begin
        if (tmr_zero) state_d = INIT_DONE;
      end
      INIT_DONE: begin
        if (reinit_req) state_d = INIT_PRECHARGE;
      end
      default: state_d = INIT_WAIT_PWR;
    endcase
    if (state_d == INIT_PRECHARGE) ref_cnt_d = '0;
  end

  // Output decode from the upcoming state so the registered pins line up with it.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = '0;
    addr_d = '0;
    done_d = 1'b0;
    case (state_d)
      INIT_PRECHARGE: begin
        cmd_d      = CMD_PRECHARGE;
        addr_d[10] = 1'b1;
      end
      INIT_AUTO_REF: begin
        cmd_d = CMD_AUTO_REF;
      end
      INIT_LOAD_MODE: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_WORD[ADDR_W-1:0];
      end
      INIT_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  // Output registers; command, address and bank update together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      init_cmd  <= CMD_NOP;
      init_ba   <= '0;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      init_cmd  <= cmd_d;
      init_ba   <= ba_d;
      init_addr <= addr_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Directed testbench for sdram_init_ctrl across several parameter sets.
module tb_sdram_init_ctrl;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reinit = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // a: defaults, P=100
  logic [3:0]  a_cmd; logic [1:0] a_ba; logic [11:0] a_addr; logic a_done;
  // b: REFRESH_CNT=8, P=100
  logic [3:0]  b_cmd; logic [1:0] b_ba; logic [11:0] b_addr; logic b_done;
  // c: 13-bit address and altered mode fields, P=100
  logic [3:0]  c_cmd; logic [1:0] c_ba; logic [12:0] c_addr; logic c_done;
  // d: minimum timings, REFRESH_CNT=3
  logic [3:0]  d_cmd; logic [1:0] d_ba; logic [11:0] d_addr; logic d_done;

  sdram_init_ctrl #(.T_POWERUP_CYC(100)) u_dut_a (
    .sys_clk(clk), .sys_rst(rst), .reinit_req(reinit),
    .init_cmd(a_cmd), .init_ba(a_ba), .init_addr(a_addr), .init_done(a_done));

  sdram_init_ctrl #(.T_POWERUP_CYC(100), .REFRESH_CNT(8)) u_dut_b (
    .sys_clk(clk), .sys_rst(rst), .reinit_req(reinit),
    .init_cmd(b_cmd), .init_ba(b_ba), .init_addr(b_addr), .init_done(b_done));

  sdram_init_ctrl #(.ADDR_W(13), .BA_W(2), .T_POWERUP_CYC(100), .CAS_LAT(2),
                    .BURST_LEN(3'b011), .WB_MODE(1)) u_dut_c (
    .sys_clk(clk), .sys_rst(rst), .reinit_req(reinit),
    .init_cmd(c_cmd), .init_ba(c_ba), .init_addr(c_addr), .init_done(c_done));

  sdram_init_ctrl #(.T_POWERUP_CYC(1), .T_RP_CYC(1), .T_RFC_CYC(1), .T_MRD_CYC(1),
                    .REFRESH_CNT(3)) u_dut_d (
    .sys_clk(clk), .sys_rst(rst), .reinit_req(reinit),
    .init_cmd(d_cmd), .init_ba(d_ba), .init_addr(d_addr), .init_done(d_done));

  // Expected {cmd, addr, done} for a P=100, tRP=2, tRFC=7, tMRD=3 sequence with n refreshes.
  function automatic logic [16:0] exp_seq(input int c, input int n);
    int          l;
    logic [3:0]  cm;
    logic [11:0] ad;
    l  = 100 + 2 + n * 7;
    cm = NOP;
    ad = 12'h000;
    if (c == 100) begin
      cm = PRE; ad = 12'h400;
    end else if (c >= 102 && c < l && ((c - 102) % 7) == 0) begin
      cm = AR;
    end else if (c == l) begin
      cm = LMR; ad = 12'h037;
    end
    return {cm, ad, (c >= l + 3)};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Two reset cycles; the next tick lands in cycle 0.
  task automatic start_seq();
    rst    = 1'b1;
    reinit = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    reinit = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({a_cmd, a_ba, a_addr, a_done} !== {NOP, 2'b00, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_a cmd=%b ba=%b addr=%h done=%b expected 0111/00/000/0", a_cmd, a_ba, a_addr, a_done);
    end
    checks++;
    if ({b_cmd, b_ba, b_addr, b_done} !== {NOP, 2'b00, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_b cmd=%b ba=%b addr=%h done=%b expected 0111/00/000/0", b_cmd, b_ba, b_addr, b_done);
    end
    checks++;
    if ({c_cmd, c_ba, c_addr, c_done} !== {NOP, 2'b00, 13'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_c cmd=%b ba=%b addr=%h done=%b expected 0111/00/0000/0", c_cmd, c_ba, c_addr, c_done);
    end
    checks++;
    if ({d_cmd, d_ba, d_addr, d_done} !== {NOP, 2'b00, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_d cmd=%b ba=%b addr=%h done=%b expected 0111/00/000/0", d_cmd, d_ba, d_addr, d_done);
    end
  endtask

  task automatic test_default_sequence();
    logic [16:0] e;
    start_seq();
    for (int c = 0; c <= 125; c++) begin
      tick();
      e = exp_seq(c, 2);
      checks++;
      if ({a_cmd, a_addr, a_done} !== e || a_ba !== 2'b00) begin
        errors++;
        $display("FAIL default c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, a_cmd, a_addr, a_ba, a_done, e[16:13], e[12:1], e[0]);
      end
    end
  endtask

  task automatic test_min_timing();
    logic [3:0]  ecmd;
    logic [11:0] eaddr;
    start_seq();
    for (int c = 0; c <= 8; c++) begin
      tick();
      case (c)
        1:       begin ecmd = PRE; eaddr = 12'h400; end
        2, 3, 4: begin ecmd = AR;  eaddr = 12'h000; end
        5:       begin ecmd = LMR; eaddr = 12'h037; end
        default: begin ecmd = NOP; eaddr = 12'h000; end
      endcase
      checks++;
      if (d_cmd !== ecmd || d_addr !== eaddr || d_ba !== 2'b00 || d_done !== (c >= 6)) begin
        errors++;
        $display("FAIL min_timing c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, d_cmd, d_addr, d_ba, d_done, ecmd, eaddr, (c >= 6));
      end
    end
  endtask

  task automatic test_refresh_count();
    logic [16:0] e;
    int ar_seen;
    ar_seen = 0;
    start_seq();
    for (int c = 0; c <= 170; c++) begin
      tick();
      if (b_cmd === AR) ar_seen++;
      e = exp_seq(c, 8);
      checks++;
      if ({b_cmd, b_addr, b_done} !== e || b_ba !== 2'b00) begin
        errors++;
        $display("FAIL refresh8 c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, b_cmd, b_addr, b_ba, b_done, e[16:13], e[12:1], e[0]);
      end
    end
    checks++;
    if (ar_seen != 8) begin
      errors++;
      $display("FAIL refresh8_count got=%0d expected=8", ar_seen);
    end
  endtask

  task automatic test_widths_mode();
    logic [16:0] e;
    logic [12:0] eaddr;
    start_seq();
    for (int c = 0; c <= 125; c++) begin
      tick();
      e     = exp_seq(c, 2);
      eaddr = (c == 100) ? 13'h0400 : (c == 116) ? 13'h0223 : 13'h0000;
      checks++;
      if (c_cmd !== e[16:13] || c_addr !== eaddr || c_ba !== 2'b00 || c_done !== e[0]) begin
        errors++;
        $display("FAIL widths c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, c_cmd, c_addr, c_ba, c_done, e[16:13], eaddr, e[0]);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [16:0] e;
    start_seq();
    for (int c = 0; c <= 104; c++) tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({a_cmd, a_ba, a_addr, a_done} !== {NOP, 2'b00, 12'h000, 1'b0}) begin
        errors++;
        $display("FAIL midreset_hold k=%0d cmd=%b ba=%b addr=%h done=%b expected 0111/00/000/0",
                 k, a_cmd, a_ba, a_addr, a_done);
      end
    end
    rst = 1'b0;
    for (int c = 0; c <= 110; c++) begin
      tick();
      e = exp_seq(c, 2);
      checks++;
      if ({a_cmd, a_addr, a_done} !== e || a_ba !== 2'b00) begin
        errors++;
        $display("FAIL midreset_restart c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, a_cmd, a_addr, a_ba, a_done, e[16:13], e[12:1], e[0]);
      end
    end
  endtask

  // Pulse during WAIT_TRFC (cycle 105) must be ignored; pulse in DONE (cycle 129)
  // restarts at PRECHARGE in cycle 130, i.e. the default timeline shifted by 30.
  task automatic test_reinit();
    logic [16:0] e;
    start_seq();
    for (int c = 0; c <= 155; c++) begin
      tick();
      e = exp_seq((c >= 130) ? c - 30 : c, 2);
      checks++;
      if ({a_cmd, a_addr, a_done} !== e || a_ba !== 2'b00) begin
        errors++;
        $display("FAIL reinit c=%0d cmd=%b addr=%h ba=%b done=%b expected cmd=%b addr=%h ba=00 done=%b",
                 c, a_cmd, a_addr, a_ba, a_done, e[16:13], e[12:1], e[0]);
      end
      reinit = (c == 105 || c == 129);
    end
    reinit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_sequence();
    test_min_timing();
    test_refresh_count();
    test_widths_mode();
    test_reset_mid_sequence();
    test_reinit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
